// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch front-end.
package fetch_queue_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fq_state_e;

  // True when the FIFO occupancy after this cycle's push/pop stays below depth.
  function automatic logic fifo_space(input int unsigned count, input logic pop,
                                      input logic push, input int unsigned depth);
    int unsigned next_cnt;
    next_cnt = count + {31'd0, push} - {31'd0, pop};
    return (next_cnt < depth);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instruction} pairs for decode.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign pop_ok_s  = pop & (count_r != {CW{1'b0}}) & ~clear;
  assign push_ok_s = push & ~clear & ((count_r != CNT_FULL) | pop_ok_s);

  // Pointer and occupancy registers; a clear empties the FIFO outright.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: owns the fetch PC, keeps one icache request in flight, buffers results.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              RW       = 16,
  parameter int              I_SIZE   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [RW-1:0]   RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              imem_req,
  output logic [RW-1:0]     imem_addr,
  output logic              imem_sync_next,
  output logic              imem_next,
  input  logic              imem_ack,
  input  logic [I_SIZE-1:0] imem_data,
  input  logic              i_branch,
  input  logic [RW-1:0]     i_branch_pc,
  output logic              o_valid,
  output logic [I_SIZE-1:0] o_instr,
  output logic [RW-1:0]     o_pc,
  input  logic              i_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = RW + I_SIZE;
  localparam logic [RW-1:0] PC_ONE = RW'(1'b1);

  fq_state_e       state_r, state_nxt_s;
  logic [RW-1:0]   pc_r, pc_nxt_s;
  logic [RW-1:0]   req_pc_r, req_pc_nxt_s;
  logic            drop_r, drop_nxt_s;
  logic [CW-1:0]   count_s;
  logic [EW-1:0]   head_s;
  logic            push_s, pop_s, clear_s;
  logic            req_s, sync_s;
  logic [RW-1:0]   addr_s;

  assign o_valid = (count_s != {CW{1'b0}});
  assign pop_s   = o_valid & i_ready;

  // State, PC and redirect bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
      drop_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      req_pc_r <= req_pc_nxt_s;
      drop_r   <= drop_nxt_s;
    end
  end

  // Next-state and request generation.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    req_pc_nxt_s = req_pc_r;
    drop_nxt_s   = drop_r;
    req_s        = 1'b0;
    sync_s       = 1'b0;
    addr_s       = pc_r;
    push_s       = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_branch) begin
          pc_nxt_s = i_branch_pc;
          clear_s  = 1'b1;
        end else if (fifo_space(32'(count_s), pop_s, 1'b0, 32'(DEPTH))) begin
          req_s        = 1'b1;
          state_nxt_s  = ST_WAIT;
          req_pc_nxt_s = pc_r;
          pc_nxt_s     = pc_r + PC_ONE;
          drop_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!imem_ack) begin
          req_s  = 1'b1;
          addr_s = req_pc_r;
          if (i_branch) begin
            // The in-flight response now belongs to the old path.
            drop_nxt_s = 1'b1;
            pc_nxt_s   = i_branch_pc;
            clear_s    = 1'b1;
          end else begin
            drop_nxt_s = drop_r;
          end
        end else begin
          push_s     = ~drop_r & ~i_branch;
          drop_nxt_s = 1'b0;
          if (i_branch) begin
            clear_s      = 1'b1;
            req_s        = 1'b1;
            sync_s       = 1'b1;
            addr_s       = i_branch_pc;
            req_pc_nxt_s = i_branch_pc;
            pc_nxt_s     = i_branch_pc + PC_ONE;
          end else if (fifo_space(32'(count_s), pop_s, push_s, 32'(DEPTH))) begin
            req_s        = 1'b1;
            sync_s       = 1'b1;
            addr_s       = pc_r;
            req_pc_nxt_s = pc_r;
            pc_nxt_s     = pc_r + PC_ONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .clear   (clear_s),
    .din     ({req_pc_r, imem_data}),
    .count   (count_s),
    .head    (head_s)
  );

  // Request strobes are forced low for as long as reset is held.
  assign imem_req       = req_s & i_rst_n;
  assign imem_sync_next = sync_s & i_rst_n;
  assign imem_addr      = addr_s;
  assign imem_next      = 1'b0;
  assign o_pc           = head_s[EW-1:I_SIZE];
  assign o_instr        = head_s[I_SIZE-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, reset corner, randomized model run.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n          [2];
  logic        imem_req       [2];
  logic [15:0] imem_addr      [2];
  logic        imem_sync_next [2];
  logic        imem_next      [2];
  logic        imem_ack       [2];
  logic [31:0] imem_data      [2];
  logic        i_branch       [2];
  logic [15:0] i_branch_pc    [2];
  logic        o_valid        [2];
  logic [31:0] o_instr        [2];
  logic [15:0] o_pc           [2];
  logic        i_ready        [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_queue #(
      .RW       (16),
      .I_SIZE   (32),
      .DEPTH    (4),
      .RESET_PC ((g == 0) ? 16'h0000 : 16'hFFFE)
    ) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n[g]),
      .imem_req       (imem_req[g]),
      .imem_addr      (imem_addr[g]),
      .imem_sync_next (imem_sync_next[g]),
      .imem_next      (imem_next[g]),
      .imem_ack       (imem_ack[g]),
      .imem_data      (imem_data[g]),
      .i_branch       (i_branch[g]),
      .i_branch_pc    (i_branch_pc[g]),
      .o_valid        (o_valid[g]),
      .o_instr        (o_instr[g]),
      .o_pc           (o_pc[g]),
      .i_ready        (i_ready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        ack;
    logic        br;
    logic [15:0] bpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_sync;
    logic        e_valid;
    logic [15:0] e_pc;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t tbl [30];

  function automatic logic [31:0] idata(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic ack, input logic br,
                              input logic [15:0] bpc, input logic e_req,
                              input logic [15:0] e_addr, input logic e_sync,
                              input logic e_valid, input logic [15:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.ack = ack; v.br = br; v.bpc = bpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_sync = e_sync;
    v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic rdy, input logic ack, input logic [31:0] dat,
                       input logic br, input logic [15:0] bpc);
    i_ready[d]     = rdy;
    imem_ack[d]    = ack;
    imem_data[d]   = dat;
    i_branch[d]    = br;
    i_branch_pc[d] = bpc;
  endtask

  // Randomized run of instance d against a queue-based reference model.
  task automatic run_random(input int d, input int ncyc, input int br_after);
    ent_t        mq[$];
    logic        outst, poison, pend;
    logic [15:0] out_addr, npc, paddr, bpcv, e_addr, wpc[3];
    int          lat, npops, nw;
    logic        rdy, brv, ackv, popv, pushv, e_req, e_sync;
    @(negedge clk);
    rst_n[d] = 1'b0;
    drive(d, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    chk($sformatf("rand%0d reset valid", d), o_valid[d], 1'b0);
    chk($sformatf("rand%0d reset req", d), imem_req[d], 1'b0);
    rst_n[d] = 1'b1;
    outst = 1'b0; poison = 1'b0; pend = 1'b0; lat = 0;
    npc = (d == 0) ? 16'h0000 : 16'hFFFE;
    out_addr = 16'h0; paddr = 16'h0; npops = 0; nw = 0;
    for (int c = 0; c < ncyc; c++) begin
      rdy  = ($urandom_range(0, 3) != 0);
      brv  = (c >= br_after) && ($urandom_range(0, 15) == 0);
      bpcv = ($urandom_range(0, 1) != 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                         : 16'($urandom_range(0, 65535));
      ackv = pend && (lat == 0);
      drive(d, rdy, ackv, ackv ? idata(paddr) : 32'($urandom), brv, bpcv);
      #1;
      popv   = (mq.size() > 0) && rdy;
      pushv  = outst && ackv && !poison && !brv;
      e_sync = 1'b0;
      e_addr = npc;
      if (!outst) begin
        e_req = !brv && ((mq.size() - int'(popv)) < 4);
      end else if (!ackv) begin
        e_req  = 1'b1;
        e_addr = out_addr;
      end else begin
        e_req  = brv || ((mq.size() - int'(popv) + int'(pushv)) < 4);
        e_addr = brv ? bpcv : npc;
        e_sync = e_req;
      end
      chk($sformatf("rand%0d c%0d valid", d, c), o_valid[d], (mq.size() != 0));
      if (mq.size() != 0) begin
        chk($sformatf("rand%0d c%0d o_pc", d, c), o_pc[d], mq[0].pc);
        chk($sformatf("rand%0d c%0d o_instr", d, c), o_instr[d], mq[0].ins);
      end
      chk($sformatf("rand%0d c%0d req", d, c), imem_req[d], e_req);
      chk($sformatf("rand%0d c%0d sync", d, c), imem_sync_next[d], e_sync);
      if (e_req) begin
        chk($sformatf("rand%0d c%0d addr", d, c), imem_addr[d], e_addr);
      end
      if (o_valid[d] && rdy) begin
        npops++;
        if (nw < 3 && c < br_after) begin
          wpc[nw] = o_pc[d];
          nw++;
        end
      end
      if (brv) begin
        mq.delete();
      end else begin
        if (popv) void'(mq.pop_front());
        if (pushv) mq.push_back('{pc: out_addr, ins: idata(out_addr)});
      end
      if (outst && !ackv) begin
        if (brv) begin
          poison = 1'b1;
          npc    = bpcv;
        end
      end else if (outst) begin
        poison = 1'b0;
        if (e_req) begin
          out_addr = e_addr;
          npc      = e_addr + 16'h0001;
        end else begin
          outst = 1'b0;
        end
      end else if (brv) begin
        npc = bpcv;
      end else if (e_req) begin
        outst    = 1'b1;
        poison   = 1'b0;
        out_addr = npc;
        npc      = npc + 16'h0001;
      end
      if (ackv) begin
        if (imem_req[d] && imem_sync_next[d]) begin
          paddr = imem_addr[d];
          lat   = $urandom_range(0, 2);
        end else begin
          pend = 1'b0;
        end
      end else if (!pend && imem_req[d]) begin
        pend  = 1'b1;
        paddr = imem_addr[d];
        lat   = $urandom_range(0, 2);
      end else if (pend && lat > 0) begin
        lat--;
      end
      @(negedge clk);
    end
    drive(d, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    if (d == 1) begin
      chk("wrap pop count >= 10", (npops >= 10), 1'b1);
      chk("wrap early pops >= 3", (nw >= 3), 1'b1);
      if (nw >= 3) begin
        chk("wrap pc0", wpc[0], 16'hFFFE);
        chk("wrap pc1", wpc[1], 16'hFFFF);
        chk("wrap pc2", wpc[2], 16'h0000);
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] dat;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      drive(d, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    end

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0000);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b1, 16'h0002);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0000);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h0003);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b1, 16'h0004);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 1'b1, 16'h0004);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b0, 1'b1, 16'h0004);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1, 1'b1, 16'h0004);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b0, 1'b1, 16'h0004);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004);
    tbl[19] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 1'b1, 16'h0004);
    tbl[20] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 1'b1, 16'h0005);
    tbl[21] = mk(1'b1, 1'b1, 1'b1, 16'h0200, 1'b1, 16'h0200, 1'b1, 1'b1, 16'h0006);
    tbl[22] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000);
    tbl[23] = mk(1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000);
    tbl[24] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000);
    tbl[25] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
    tbl[26] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b1, 1'b0, 16'h0000);
    tbl[27] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0, 1'b1, 16'h0100);
    tbl[28] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b1, 1'b0, 16'h0000);
    tbl[29] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b0, 1'b1, 16'h0101);

    repeat (3) @(negedge clk);
    chk("reset valid", o_valid[0], 1'b0);
    chk("reset req", imem_req[0], 1'b0);
    chk("reset sync", imem_sync_next[0], 1'b0);
    chk("reset next", imem_next[0], 1'b0);

    // Directed table: in-order fetch, full stall, redirects in ack and wait cycles.
    rst_n[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      v   = tbl[i];
      dat = (i > 0 && v.ack) ? idata(tbl[i-1].e_addr) : 32'hDEAD_BEEF;
      drive(0, v.rdy, v.ack, dat, v.br, v.bpc);
      #1;
      chk($sformatf("row%0d req", i), imem_req[0], v.e_req);
      chk($sformatf("row%0d sync", i), imem_sync_next[0], v.e_sync);
      chk($sformatf("row%0d next", i), imem_next[0], 1'b0);
      chk($sformatf("row%0d valid", i), o_valid[0], v.e_valid);
      if (v.e_req) chk($sformatf("row%0d addr", i), imem_addr[0], v.e_addr);
      if (v.e_valid) begin
        chk($sformatf("row%0d o_pc", i), o_pc[0], v.e_pc);
        chk($sformatf("row%0d o_instr", i), o_instr[0], idata(v.e_pc));
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a wait, then a stale ack after release.
    drive(0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    #1;
    chk("pre-reset valid", o_valid[0], 1'b1);
    chk("pre-reset req", imem_req[0], 1'b1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("async reset valid", o_valid[0], 1'b0);
    chk("async reset req", imem_req[0], 1'b0);
    chk("async reset sync", imem_sync_next[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 16'h0);
    #1;
    chk("post-reset req", imem_req[0], 1'b1);
    chk("post-reset addr", imem_addr[0], 16'h0000);
    chk("post-reset sync", imem_sync_next[0], 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0);
    #1;
    chk("stale ack not pushed", o_valid[0], 1'b0);
    chk("post-reset held addr", imem_addr[0], 16'h0000);
    chk("post-reset held req", imem_req[0], 1'b1);
    @(negedge clk);

    run_random(0, 400, 0);
    run_random(1, 300, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end sitting directly upstream of the instruction cache; the decode stage consumes its output.
- Owns the fetch PC and issues sequential word fetches over the cache's imem request port.
- Buffers returned instructions, each with its PC, in a small FIFO for decode.
- Handles branch redirects, including discarding a response that is still in flight.

Parameters:
RW, 16, address/PC width (word address)
I_SIZE, 32, instruction width
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 0, PC loaded at reset

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request to icache
imem_addr  out  RW  fetch word address
imem_sync_next  out  1  back-to-back request presented during an ack cycle
imem_next  out  1  tied 0 (pre-next mode unused)
imem_ack  in  1  one-cycle response strobe from icache
imem_data  in  I_SIZE  instruction, valid while imem_ack=1
i_branch  in  1  redirect strobe, one cycle
i_branch_pc  in  RW  redirect target
o_valid  out  1  FIFO head valid
o_instr  out  I_SIZE  head instruction
o_pc  out  RW  head PC
i_ready  in  1  decode pops head when o_valid&i_ready

Behaviour:
- Reset (async assert, sync release): state IDLE; pc=RESET_PC; FIFO empty; drop=0.
  - Outputs in reset: o_valid=0, imem_req=0, imem_sync_next=0, imem_next=0.
- State WAIT means exactly one request is outstanding. At most one is ever outstanding.
- Registers: pc (address of the next fetch), req_pc (in-flight address), drop flag, FIFO rd/wr pointers, count (0..DEPTH).
- Request outputs are combinational from state and imem_ack.
- The icache accepts a request on an edge where req&~ack, or req&ack&sync_next. It re-accepts a held req once ack falls.
  - imem_req must therefore be low in the cycle after an ack unless a new request was issued in the ack cycle.
- space = count - pop + push < DEPTH, evaluated for the current cycle.
- IDLE:
  - If space (push=0): imem_req=1, imem_addr=pc.
  - Next edge: WAIT, req_pc<=pc, pc<=pc+1.
  - If i_branch in the same cycle, branch wins: no request; pc<=i_branch_pc, FIFO cleared.
- WAIT, imem_ack=0:
  - imem_req=1, imem_addr=req_pc, sync_next=0.
  - i_branch: drop<=1, pc<=i_branch_pc, FIFO cleared.
- WAIT, imem_ack=1:
  - If ~drop and no i_branch: push {req_pc, imem_data}.
  - Next fetch in the same cycle (imem_req=1, sync_next=1):
    - addr = i_branch ? i_branch_pc : pc, if space including this push.
    - State stays WAIT; req_pc<=addr, pc<=addr+1, drop<=0.
  - No space: imem_req=0, next state IDLE, drop<=0.
  - i_branch in an ack cycle: data discarded, FIFO cleared, redirect fetch issued the same cycle.
- Pop: o_valid=(count!=0); o_instr/o_pc are the head entry.
  - Simultaneous push and pop keeps count unchanged.
  - A branch clear overrides push/pop.
- Wrap-around:
  - PC increments modulo 2^RW (0xFFFF -> 0x0000).
  - FIFO pointers wrap modulo DEPTH.
- Latency: first instruction reaches o_valid one cycle after the icache ack, i.e. registered FIFO write. Throughput is limited only by the icache.
- Reset mid-transaction returns the block to IDLE with the FIFO empty. A stale ack arriving after release while in IDLE is ignored.

Decomposition:
- Shared config include: RW, I_SIZE (existing macros).
- Sub-module fetch_fifo: DEPTH x (RW+I_SIZE) synchronous FIFO.
  - Inputs: push, pop, clear.
  - Outputs: count, head.
  - Also reset by i_rst_n.
- FSM and PC logic stay in fetch_queue.

Test Plan:
1. Reset release, i_ready=1, icache model acking every 2 cycles: fetches at 0,1,2,3 in order; o_pc sequence 0,1,2,3 with matching data; sync_next=1 on each ack cycle.
2. i_ready=0 for 10 cycles with DEPTH=4: exactly 4 pushes. imem_req falls after the 4th ack; no request while full. Raising i_ready resumes fetch at PC 4.
3. i_branch to 0x0100 while WAIT on PC 2: ack for PC 2 discarded, FIFO empty. Next request addr=0x0100; first o_pc=0x0100.
4. i_branch to 0x0200 coincident with imem_ack: data dropped; same cycle imem_addr=0x0200 with sync_next=1.
5. RESET_PC=0xFFFE: o_pc sequence 0xFFFE, 0xFFFF, 0x0000; FIFO pointer wrap over 10 pushes with interleaved pops, with no loss or duplication.
6. Assert i_rst_n=0 asynchronously mid-WAIT: o_valid and imem_req go low immediately. After release the first request is addr=RESET_PC.
